// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with valid/ready handshakes and a two-entry (main + skid) output buffer.
// in_ready is registered, so it does not depend combinationally on out_ready.
module alu_exec_stage #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              ovf,
    output logic              illegal,
    output logic [TAG_W-1:0]  out_tag
);

    localparam logic [3:0] CTRL_AND    = 4'b0000;
    localparam logic [3:0] CTRL_OR     = 4'b0001;
    localparam logic [3:0] CTRL_ADD    = 4'b0010;
    localparam logic [3:0] CTRL_SUB    = 4'b0110;
    localparam logic [3:0] CTRL_DOUBLE = 4'b0100;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              zero;
        logic              ovf;
        logic              illegal;
        logic [TAG_W-1:0]  tag;
    } entry_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_TWO   = 2'd2
    } buf_state_t;

    buf_state_t  state_reg;
    entry_t      main_reg;
    entry_t      skid_reg;
    entry_t      alu_next;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        accept;
    logic        pop;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              sign_a;
    logic              sign_b;

    assign sum    = op_a + op_b;
    assign diff   = op_a - op_b;
    assign sign_a = op_a[DATA_W-1];
    assign sign_b = op_b[DATA_W-1];

    always_comb begin
        alu_next         = '0;
        alu_next.tag     = in_tag;
        case (alu_ctrl)
            CTRL_AND:    alu_next.result = op_a & op_b;
            CTRL_OR:     alu_next.result = op_a | op_b;
            CTRL_ADD: begin
                alu_next.result = sum;
                alu_next.ovf    = (sign_a == sign_b) && (sum[DATA_W-1] != sign_a);
            end
            CTRL_SUB: begin
                alu_next.result = diff;
                alu_next.ovf    = (sign_a != sign_b) && (diff[DATA_W-1] != sign_a);
            end
            CTRL_DOUBLE: alu_next.result = {op_a[DATA_W-2:0], 1'b0};
            default:     alu_next.illegal = 1'b1;
        endcase
        // Illegal codes still produce a zero result, so zero reads 1 for them too.
        alu_next.zero = (alu_next.result == '0);
    end

    assign accept = in_valid && in_ready_reg;
    assign pop    = out_valid_reg && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= BUF_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_reg      <= '0;
            skid_reg      <= '0;
        end else if (flush) begin
            // Any offered input is dropped; a pop this cycle is already consumed downstream.
            state_reg     <= BUF_EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            main_reg      <= '0;
            skid_reg      <= '0;
        end else begin
            case (state_reg)
                BUF_EMPTY: begin
                    if (accept) begin
                        main_reg      <= alu_next;
                        out_valid_reg <= 1'b1;
                        state_reg     <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (accept && pop) begin
                        main_reg <= alu_next;
                    end else if (accept) begin
                        skid_reg     <= alu_next;
                        in_ready_reg <= 1'b0;
                        state_reg    <= BUF_TWO;
                    end else if (pop) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (pop) begin
                        main_reg     <= skid_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= BUF_ONE;
                    end
                end
                default: begin
                    state_reg     <= BUF_EMPTY;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = main_reg.result;
    assign zero      = main_reg.zero;
    assign ovf       = main_reg.ovf;
    assign illegal   = main_reg.illegal;
    assign out_tag   = main_reg.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed-vector bench for alu_exec_stage with hand-computed expectations.
module tb_alu_exec_stage;

    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        alu_ctrl;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              ovf;
    logic              illegal;
    logic [TAG_W-1:0]  out_tag;

    int checks = 0;
    int errors = 0;

    alu_exec_stage #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
        alu_ctrl = ctrl;
        op_a     = a;
        op_b     = b;
        in_tag   = tag;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [31:0] r, input logic z,
                              input logic o, input logic il, input logic [4:0] tg);
        check({name, ".valid"},   out_valid, 1'b1);
        check({name, ".result"},  result, r);
        check({name, ".zero"},    zero, z);
        check({name, ".ovf"},     ovf, o);
        check({name, ".illegal"}, illegal, il);
        check({name, ".tag"},     out_tag, tg);
    endtask

    task automatic expect_reset(input string name);
        check({name, ".out_valid"}, out_valid, 1'b0);
        check({name, ".in_ready"},  in_ready, 1'b1);
        check({name, ".result"},    result, 32'd0);
        check({name, ".zero"},      zero, 1'b0);
        check({name, ".ovf"},       ovf, 1'b0);
        check({name, ".illegal"},   illegal, 1'b0);
        check({name, ".tag"},       out_tag, 5'd0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        alu_ctrl = 4'b0; op_a = '0; op_b = '0; in_tag = '0;
        repeat (2) tick();
        rst = 1'b0;
        expect_reset("reset");

        // Streaming ops with out_ready=1: each result visible one cycle after accept.
        send(4'b0010, 32'd7, 32'd5, 5'd3);
        expect_out("add", 32'd12, 1'b0, 1'b0, 1'b0, 5'd3);
        send(4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd4);
        expect_out("sub_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd4);
        send(4'b0110, 32'd9, 32'd9, 5'd5);
        expect_out("sub_zero", 32'd0, 1'b1, 1'b0, 1'b0, 5'd5);
        send(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd6);
        expect_out("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 5'd6);
        send(4'b0100, 32'h4000_0001, 32'h0000_DEAD, 5'd7);
        expect_out("double", 32'h8000_0002, 1'b0, 1'b0, 1'b0, 5'd7);
        send(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 5'd8);
        expect_out("and", 32'h0000_F000, 1'b0, 1'b0, 1'b0, 5'd8);
        send(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 5'd9);
        expect_out("or", 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 5'd9);
        tick();
        check("drain.out_valid", out_valid, 1'b0);

        // Stall: two back-to-back ops fill main and skid.
        out_ready = 1'b0;
        send(4'b0010, 32'd1, 32'd1, 5'd1);
        check("stall1.in_ready", in_ready, 1'b1);
        expect_out("stall1", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        send(4'b0010, 32'd2, 32'd2, 5'd2);
        check("stall2.in_ready", in_ready, 1'b0);
        expect_out("stall2_hold", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        tick();
        expect_out("stall2_still", 32'd2, 1'b0, 1'b0, 1'b0, 5'd1);
        out_ready = 1'b1;
        tick();
        check("pop1.in_ready", in_ready, 1'b1);
        expect_out("pop_skid", 32'd4, 1'b0, 1'b0, 1'b0, 5'd2);
        tick();
        check("pop2.out_valid", out_valid, 1'b0);

        // Flush with both entries held and a new op offered.
        out_ready = 1'b0;
        send(4'b0010, 32'd10, 32'd0, 5'd4);
        send(4'b0010, 32'd11, 32'd0, 5'd5);
        check("pre_flush.in_ready", in_ready, 1'b0);
        flush = 1'b1;
        alu_ctrl = 4'b0010; op_a = 32'd12; op_b = 32'd0; in_tag = 5'd6; in_valid = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_flush.out_valid", out_valid, 1'b0);
        end

        // Illegal code still flows through, then rst during a stall discards everything.
        out_ready = 1'b0;
        send(4'b1111, 32'd5, 32'd6, 5'd7);
        expect_out("illegal", 32'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        send(4'b0010, 32'd3, 32'd4, 5'd8);
        check("illegal_stall.in_ready", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_reset("mid_stall_rst");
        out_ready = 1'b1;
        tick();
        check("after_rst.out_valid", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
